divisor_punto_fijo: RTL and testbench

- Sequential signed fixed-point divider, the inverse operation to the team's saturating fixed-point multiplier.
- Computes Y = A / B in the same Q format: Width bits, Presicion fraction bits, two's complement.
- Uses an unsigned restoring shift-subtract core with one quotient bit per clock. Sign and saturation are applied at the end.
- Sits in the arithmetic datapath next to the multiplier. Controlled by the system FSM through a start/done handshake.

---
 rtl/divisor_punto_fijo.sv | 151 +++++++++++++++
 tb/tb_divisor_punto_fijo.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divisor_punto_fijo.sv
// Sequential signed fixed-point divider, Q(Magnitud.Presicion) two's complement.
// Unsigned restoring shift-subtract core producing one quotient bit per clock;
// sign and symmetric saturation are applied when the result is registered.
// Latency from the accepting edge to the done cycle is constant (ITER+1 cycles).
module divisor_punto_fijo #(
  parameter int Width     = 23,
  parameter int Presicion = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [Width-1:0] A,
  input  logic [Width-1:0] B,
  output logic [Width-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int Magnitud = Width - Presicion - 1;
  // Quotient bits produced by the CALC phase: the dividend |A| << Presicion
  // has ITER+1 bits, its MSB is consumed when the operands are latched.
  localparam int ITER = Width - 1 + Presicion;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [Width-1:0] MAXIMO = {1'b0, {(Width-1){1'b1}}};
  localparam logic [Width-1:0] MINIMO = {1'b1, {(Width-2){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [Width-1:0] r_rem;     // partial remainder, always < |B|
  logic [ITER-1:0]  r_dq;      // dividend bits shift out the top, quotient bits shift in
  logic [Width-1:0] r_b_abs;
  logic             r_sign;
  logic             r_qtop;    // quotient bit of weight 2^ITER (only |A|=2^(Width-1), |B|=1)
  logic             r_a_neg;
  logic             r_a_zero;

  // Operand magnitudes; -2^(Width-1) maps exactly to 2^(Width-1) as unsigned.
  logic [Width-1:0] w_a_abs;
  logic [Width-1:0] w_b_abs;
  logic             w_top;
  logic             w_b_one;
  assign w_a_abs = A[Width-1] ? -A : A;
  assign w_b_abs = B[Width-1] ? -B : B;
  assign w_top   = w_a_abs[Width-1];
  assign w_b_one = (w_b_abs == {{(Width-1){1'b0}}, 1'b1});

  // One restoring step: shift in the next dividend bit, subtract when it fits.
  logic [Width:0]   w_shift;
  logic             w_ge;
  logic [Width-1:0] w_diff;
  logic [Width-1:0] w_rem_next;
  logic [ITER-1:0]  w_dq_next;
  assign w_shift    = {r_rem, r_dq[ITER-1]};
  assign w_ge       = (w_shift >= {1'b0, r_b_abs});
  // The true difference is below |B|, so the modular Width-bit result is exact.
  assign w_diff     = w_shift[Width-1:0] - r_b_abs;
  assign w_rem_next = w_ge ? w_diff : w_shift[Width-1:0];
  assign w_dq_next  = {r_dq[ITER-2:0], w_ge};

  // Final quotient magnitude exceeds MAXIMO when any bit above the Q range is set.
  logic             w_ovf;
  logic [Width-1:0] w_mag;
  assign w_ovf = r_qtop | (|w_dq_next[ITER-1:Magnitud+Presicion]);
  assign w_mag = {1'b0, w_dq_next[Magnitud+Presicion-1:0]};

  // Signed, saturated result for the step that completes the division.
  logic [Width-1:0] w_result;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_result = '0;
    if (div_zero) begin
      if (r_a_zero)     w_result = '0;
      else if (r_a_neg) w_result = MINIMO;
      else              w_result = MAXIMO;
    end else if (w_ovf) begin
      w_result = r_sign ? MINIMO : MAXIMO;
    end else begin
      w_result = r_sign ? -w_mag : w_mag;
    end
  end

  // Control FSM and datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples values from before the edge regardless of statement order.
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_dq     <= '0;
      r_b_abs  <= '0;
      r_sign   <= 1'b0;
      r_qtop   <= 1'b0;
      r_a_neg  <= 1'b0;
      r_a_zero <= 1'b0;
      Y        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sign   <= A[Width-1] ^ B[Width-1];
            r_a_neg  <= A[Width-1];
            r_a_zero <= (A == '0);
            r_b_abs  <= w_b_abs;
            r_dq     <= {w_a_abs[Width-2:0], {Presicion{1'b0}}};
            // Dividend MSB is processed here so CALC needs exactly ITER steps.
            r_rem    <= {{(Width-1){1'b0}}, w_top & ~w_b_one};
            r_qtop   <= w_top & w_b_one;
            r_cnt    <= CW'(ITER);
            div_zero <= (B == '0);
            busy     <= 1'b1;
            // A zero divisor still walks through CALC as a timed wait; its
            // quotient is discarded, which keeps the latency constant.
            r_state  <= S_CALC;
          end
        end
        S_CALC: begin
          r_rem <= w_rem_next;
          r_dq  <= w_dq_next;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            Y       <= w_result;
            done    <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_punto_fijo.sv
// Self-checking bench for divisor_punto_fijo: directed cases from the
// datasheet examples plus randomized operands checked against an
// arithmetic reference model.
module tb_divisor_punto_fijo;

  localparam int W   = 23;
  localparam int P   = 14;
  localparam int LAT = 37;
  localparam longint MAXV = (longint'(1) << (W-1)) - 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic [W-1:0] Y;
  logic         busy;
  logic         done;
  logic         div_zero;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  divisor_punto_fijo dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .A        (A),
    .B        (B),
    .Y        (Y),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero)
  );

  // Reference: exact rational quotient, truncated toward zero, symmetric saturation.
  function automatic logic [W-1:0] model_div(input logic [W-1:0] a_bits, input logic [W-1:0] b_bits);
    longint a, b, q, r;
    a = longint'($signed(a_bits));
    b = longint'($signed(b_bits));
    if (b == 0) begin
      if (a == 0)     r = 0;
      else if (a > 0) r = MAXV;
      else            r = -MAXV;
    end else begin
      q = ((a < 0) ? -a : a) * (longint'(1) << P);
      q = q / ((b < 0) ? -b : b);
      if (q > MAXV) q = MAXV;
      r = ((a < 0) != (b < 0)) ? -q : q;
    end
    return r[W-1:0];
  endfunction

  // Issues one division and waits for done; checks latency and busy along the way.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] y, output logic dz);
    int  n;
    int  busy_low;
    bit  seen;
    @(negedge clk);
    A = a; B = b; start = 1'b1;
    n = 0; busy_low = 0; seen = 1'b0;
    while (!seen && n < LAT + 20) begin
      @(negedge clk);
      n++;
      if (!busy) busy_low++;
      if (done) seen = 1'b1;
      if (n == 1) begin
        start = 1'b0;
        A = W'($urandom);
        B = W'($urandom);
      end
    end
    n_cmp++;
    if (!seen || n != LAT || busy_low != 0) begin
      n_err++;
      $display("FAIL latency a=%0d b=%0d: done_seen=%0d cycle=%0d busy_low=%0d, required done at cycle %0d with busy high",
               $signed(a), $signed(b), seen, n, busy_low, LAT);
    end
    y  = Y;
    dz = div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; A = '0; B = '0;
    #12;
    n_cmp++;
    if ({Y, busy, done, div_zero} !== '0) begin
      n_err++;
      $display("FAIL reset_state: Y=%0d busy=%0b done=%0b dz=%0b, required all zero", Y, busy, done, div_zero);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [2] = '{W'(49152), W'(-16384)};
    logic [W-1:0] tb [2] = '{W'(32768), W'(65536)};
    logic [W-1:0] te [2] = '{W'(24576), W'(-4096)};
    logic [W-1:0] y;
    logic dz;
    for (int i = 0; i < 2; i++) begin
      run_op(ta[i], tb[i], y, dz);
      n_cmp++;
      if (y !== te[i] || dz !== 1'b0) begin
        n_err++;
        $display("FAIL basic_%0d: Y=%0d dz=%0b, required Y=%0d dz=0", i, $signed(y), dz, $signed(te[i]));
      end
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || Y !== te[1]) begin
      n_err++;
      $display("FAIL after_done: done=%0b busy=%0b Y=%0d, required 0 0 %0d", done, busy, $signed(Y), $signed(te[1]));
    end
  endtask

  task automatic test_truncation();
    logic [W-1:0] ta [3] = '{W'(16384), W'(-16384), W'(1)};
    logic [W-1:0] te [3] = '{W'(5461), W'(-5461), W'(0)};
    logic [W-1:0] y;
    logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], W'(49152), y, dz);
      n_cmp++;
      if (y !== te[i]) begin
        n_err++;
        $display("FAIL trunc_%0d: Y=%0d, required %0d", i, $signed(y), $signed(te[i]));
      end
    end
  endtask

  task automatic test_overflow();
    logic [W-1:0] ta [3] = '{W'(3276800), W'(3276800), W'(-4194304)};
    logic [W-1:0] tb [3] = '{W'(8192), W'(-8192), W'(1)};
    logic [W-1:0] te [3] = '{W'(4194303), W'(-4194303), W'(-4194303)};
    logic [W-1:0] y;
    logic dz;
    for (int i = 0; i < 3; i++) begin
      run_op(ta[i], tb[i], y, dz);
      n_cmp++;
      if (y !== te[i] || dz !== 1'b0) begin
        n_err++;
        $display("FAIL ovf_%0d: Y=%0d dz=%0b, required Y=%0d dz=0", i, $signed(y), dz, $signed(te[i]));
      end
    end
  endtask

  task automatic test_div_zero();
    logic [W-1:0] ta [4] = '{W'(5), W'(-5), W'(0), W'(16384)};
    logic [W-1:0] tb [4] = '{W'(0), W'(0), W'(0), W'(16384)};
    logic [W-1:0] te [4] = '{W'(4194303), W'(-4194303), W'(0), W'(16384)};
    logic         td [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [W-1:0] y;
    logic dz;
    for (int i = 0; i < 4; i++) begin
      run_op(ta[i], tb[i], y, dz);
      n_cmp++;
      if (y !== te[i] || dz !== td[i]) begin
        n_err++;
        $display("FAIL divzero_%0d: Y=%0d dz=%0b, required Y=%0d dz=%0b", i, $signed(y), dz, $signed(te[i]), td[i]);
      end
    end
  endtask

  task automatic test_abort();
    int pulses;
    logic [W-1:0] y;
    logic dz;
    @(negedge clk);
    A = W'(49152); B = W'(16384); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({Y, busy, done, div_zero} !== '0) begin
      n_err++;
      $display("FAIL abort_reset: Y=%0d busy=%0b done=%0b dz=%0b, required all zero", $signed(Y), busy, done, div_zero);
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (done || busy) pulses++;
    end
    n_cmp++;
    if (pulses != 0 || Y !== '0) begin
      n_err++;
      $display("FAIL abort_quiet: active_cycles=%0d Y=%0d, required 0 and 0", pulses, $signed(Y));
    end
    run_op(W'(32768), W'(16384), y, dz);
    n_cmp++;
    if (y !== W'(32768)) begin
      n_err++;
      $display("FAIL abort_restart: Y=%0d, required 32768", $signed(y));
    end
  endtask

  task automatic test_back_to_back();
    int first_done;
    int second_done;
    int n_done;
    logic [W-1:0] y1;
    logic [W-1:0] y2;
    @(negedge clk);
    A = W'(49152); B = W'(32768); start = 1'b1;
    first_done = -1; second_done = -1; n_done = 0;
    y1 = '0; y2 = '0;
    for (int n = 1; n <= 80; n++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (first_done < 0) begin first_done = n; y1 = Y; end
        else begin second_done = n; y2 = Y; end
      end
      case (n)
        1:  start = 1'b0;
        5:  begin start = 1'b1; A = W'(16384); B = W'(16384); end
        6:  start = 1'b0;
        37: begin start = 1'b1; A = W'(1000); B = W'(7); end
        38: begin start = 1'b1; A = W'(-32768); B = W'(16384); end
        39: start = 1'b0;
        default: ;
      endcase
    end
    n_cmp++;
    if (first_done != LAT || y1 !== W'(24576)) begin
      n_err++;
      $display("FAIL b2b_first: done at %0d Y=%0d, required done at %0d Y=24576", first_done, $signed(y1), LAT);
    end
    n_cmp++;
    if (second_done != 38 + LAT || y2 !== W'(-32768) || n_done != 2) begin
      n_err++;
      $display("FAIL b2b_second: done at %0d Y=%0d pulses=%0d, required done at %0d Y=-32768 pulses=2",
               second_done, $signed(y2), n_done, 38 + LAT);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, y, e;
    logic dz;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      case ($urandom_range(0, 3))
        0: b = W'($urandom);
        1: b = W'($urandom) >> $urandom_range(0, W-1);
        2: b = W'($urandom_range(0, 3));
        default: begin a = {1'b1, {(W-1){1'b0}}}; b = W'($urandom) >> $urandom_range(0, W-1); end
      endcase
      if ($urandom_range(0, 1) == 1) b = -b;
      if ($urandom_range(0, 7) == 0) a = W'($urandom_range(0, 3));
      e = model_div(a, b);
      run_op(a, b, y, dz);
      n_cmp++;
      if (y !== e || dz !== (b == '0)) begin
        n_err++;
        $display("FAIL random_%0d a=%0d b=%0d: Y=%0d dz=%0b, required Y=%0d dz=%0b",
                 i, $signed(a), $signed(b), $signed(y), dz, $signed(e), (b == '0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_overflow();
    test_div_zero();
    test_abort();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
